// File: rtl/player_pkg.sv
// player_pkg: shared state encoding and default timing constants for the player life sequencer.
package player_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ALIVE     = 3'd1,
    EXPLODING = 3'd2,
    RESPAWN   = 3'd3,
    GAME_OVER = 3'd4
  } player_state_t;
  localparam logic [2:0] DEF_MAX_LIVES      = 3'h3;
  localparam int         DEF_EXPLODE_FRAMES = 30;
  localparam int         DEF_INVULN_FRAMES  = 90;
endpackage

// File: rtl/player_life_ctrl_frame_timer.sv
// frame_timer: frame-tick counter with synchronous clear; done fires on the tick that reaches limit.
module frame_timer #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             tick,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count_nxt,
  output logic             done
);
  logic [CNT_W-1:0] r_count;
  assign count_nxt = clear ? '0 : r_count + CNT_W'(tick);
  assign done      = (r_count == limit) & tick;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_count <= '0;
    else     r_count <= count_nxt;
endmodule

// File: rtl/player_life_ctrl.sv
// player_life_ctrl: player life-cycle FSM (alive/exploding/respawn/game over) timed in video frames.
// Define PLAYER_BLINK_EN to blink the sprite during RESPAWN with half-period BLINK_FRAMES.
module player_life_ctrl
  import player_pkg::*;
#(
  parameter logic [2:0] MAX_LIVES      = DEF_MAX_LIVES,
  parameter int         EXPLODE_FRAMES = DEF_EXPLODE_FRAMES,
  parameter int         INVULN_FRAMES  = DEF_INVULN_FRAMES,
  parameter int         BLINK_FRAMES   = 8,
  parameter int         CNT_W          = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_game,
  input  logic       frame_tick,
  input  logic       hit,
  output logic [2:0] lives_left,
  output logic       explosion,
  output logic       player_visible,
  output logic       invulnerable,
  output logic       game_over,
  output logic [2:0] state
);
  player_state_t    r_state, w_next;
  logic [2:0]       r_lives;
  logic             r_expl, r_vis, r_inv, r_go;
  logic [CNT_W-1:0] w_limit, w_cnt_nxt;
  logic             w_clear, w_done, w_vis_resp;
  assign w_limit = (r_state == EXPLODING) ? CNT_W'(EXPLODE_FRAMES - 1) : CNT_W'(INVULN_FRAMES - 1);
  assign w_clear = (w_next != r_state);
  frame_timer #(.CNT_W(CNT_W)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (w_clear),
    .tick      (frame_tick),
    .limit     (w_limit),
    .count_nxt (w_cnt_nxt),
    .done      (w_done)
  );
`ifdef PLAYER_BLINK_EN
  assign w_vis_resp = ~w_cnt_nxt[$clog2(BLINK_FRAMES)];
`else
  assign w_vis_resp = 1'b1;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, GAME_OVER: if (start_game) w_next = ALIVE;
      ALIVE:           if (hit) w_next = EXPLODING;
      EXPLODING:       if (w_done) w_next = (r_lives == 3'd0) ? GAME_OVER : RESPAWN;
      RESPAWN:         if (w_done) w_next = ALIVE;
      default:         w_next = IDLE;
    endcase
  end
  // Flags are decoded from the next state so they change on the same edge as state.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_lives <= MAX_LIVES;
      r_expl  <= 1'b0;
      r_vis   <= 1'b0;
      r_inv   <= 1'b0;
      r_go    <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == IDLE || r_state == GAME_OVER) && start_game) r_lives <= MAX_LIVES;
      else if (r_state == ALIVE && hit) r_lives <= (r_lives == 3'd0) ? 3'd0 : r_lives - 3'd1;
      r_expl  <= (w_next == EXPLODING);
      r_vis   <= (w_next == ALIVE) || (w_next == RESPAWN && w_vis_resp);
      r_inv   <= (w_next == RESPAWN);
      r_go    <= (w_next == GAME_OVER);
    end
  assign state          = r_state;
  assign lives_left     = r_lives;
  assign explosion      = r_expl;
  assign player_visible = r_vis;
  assign invulnerable   = r_inv;
  assign game_over      = r_go;
endmodule
